// File: rtl/alu_acc.sv
// -----------------------------------------------------------------------------
// alu_acc: registered accumulator ALU with a valid/ready/done handshake.
//
// The accumulator A, the carry/borrow flag CY and the zero flag Z live in
// registers. R comes from the register file on IN_R. Every operation except
// MUL commits at the edge that accepts it. MUL runs as a WIDTH-step
// shift-add sequence, and the block is busy while it runs.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous, active-high reset
//   IN_VALID   operation request; it is taken only while OUT_READY is high
//   IN_OP      operation code (0..11 legal, 12..15 illegal)
//   IN_R       operand R
//   OUT_READY  an operation can be accepted this cycle
//   OUT_DONE   one-cycle pulse after a result is committed
//   OUT_ERR    one-cycle pulse, together with OUT_DONE, for an illegal op
//   OUT_A      accumulator contents
//   OUT_CY     carry/borrow flag
//   OUT_Z      zero flag (OUT_A == 0)
//
// FSM states
//   state  | meaning
//   S_IDLE | ready; single-cycle ops commit at the accepting edge
//   S_MUL  | busy; one shift-add step per edge, WIDTH steps in total
// -----------------------------------------------------------------------------
module alu_acc #(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   input  logic [3:0]       IN_OP,
   input  logic [WIDTH-1:0] IN_R,
   output logic             OUT_READY,
   output logic             OUT_DONE,
   output logic             OUT_ERR,
   output logic [WIDTH-1:0] OUT_A,
   output logic             OUT_CY,
   output logic             OUT_Z
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_OR  = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LD  = 4'd6;
   localparam logic [3:0] OP_ADC = 4'd7;
   localparam logic [3:0] OP_SBB = 4'd8;
   localparam logic [3:0] OP_SHL = 4'd9;
   localparam logic [3:0] OP_SHR = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic               cy_q, cy_d;
   logic               z_q, z_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   // Single-cycle datapath results
   logic               carry_in;
   logic               borrow_in;
   logic [WIDTH:0]     add_res;
   logic [WIDTH:0]     sub_res;
   logic [WIDTH-1:0]   alu_a;
   logic               alu_cy;
   logic               op_illegal;
   logic               op_mul;

   // Multiply step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_step;
   logic               mul_last;

   // ADC/SBB reuse the ADD/SUB adders with the stored flag as carry/borrow in.
   assign carry_in  = (IN_OP == OP_ADC) ? cy_q : 1'b0;
   assign borrow_in = (IN_OP == OP_SBB) ? cy_q : 1'b0;

   // The subtraction is done one bit wider than the datapath. The lowest
   // possible value is -2^WIDTH, so the extra top bit is set exactly when
   // the result is negative, which is the borrow.
   assign add_res = {1'b0, a_q} + {1'b0, IN_R} + {{WIDTH{1'b0}}, carry_in};
   assign sub_res = {1'b0, a_q} - {1'b0, IN_R} - {{WIDTH{1'b0}}, borrow_in};

   always_comb begin
      alu_a      = a_q;
      alu_cy     = cy_q;
      op_illegal = 1'b0;
      op_mul     = 1'b0;
      case (IN_OP)
         OP_ADD, OP_ADC: begin
            alu_a  = add_res[WIDTH-1:0];
            alu_cy = add_res[WIDTH];
         end
         OP_SUB, OP_SBB: begin
            alu_a  = sub_res[WIDTH-1:0];
            alu_cy = sub_res[WIDTH];
         end
         OP_OR: begin
            alu_a  = a_q | IN_R;
            alu_cy = 1'b0;
         end
         OP_AND: begin
            alu_a  = a_q & IN_R;
            alu_cy = 1'b0;
         end
         OP_XOR: begin
            alu_a  = a_q ^ IN_R;
            alu_cy = 1'b0;
         end
         OP_NOT: begin
            alu_a  = ~a_q;
            alu_cy = 1'b0;
         end
         OP_LD: begin
            alu_a  = IN_R;
         end
         OP_SHL: begin
            alu_a  = {a_q[WIDTH-2:0], 1'b0};
            alu_cy = a_q[WIDTH-1];
         end
         OP_SHR: begin
            alu_a  = {1'b0, a_q[WIDTH-1:1]};
            alu_cy = a_q[0];
         end
         OP_MUL: begin
            if (MUL_EN != 0) begin
               op_mul = 1'b1;
            end else begin
               op_illegal = 1'b1;
            end
         end
         default: begin
            op_illegal = 1'b1;
         end
      endcase
   end

   // The upper half of prod holds the partial product and the lower half
   // starts out holding the multiplier. Each step adds the multiplicand into
   // the upper half when the current multiplier bit (prod[0]) is set. Then
   // the whole register shifts right. After WIDTH steps the multiplier bits
   // have all been consumed and prod holds the full 2*WIDTH-bit product.
   assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};
   assign mul_last  = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      cy_d    = cy_q;
      z_d     = z_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (IN_VALID) begin
               if (op_illegal) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (op_mul) begin
                  state_d = S_MUL;
                  mcand_d = a_q;
                  prod_d  = {{WIDTH{1'b0}}, IN_R};
                  cnt_d   = '0;
               end else begin
                  a_d    = alu_a;
                  cy_d   = alu_cy;
                  z_d    = (alu_a == '0);
                  done_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + CW'(1);
            if (mul_last) begin
               state_d = S_IDLE;
               a_d     = prod_step[WIDTH-1:0];
               cy_d    = |prod_step[2*WIDTH-1:WIDTH];
               z_d     = (prod_step[WIDTH-1:0] == '0);
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         cy_q    <= 1'b0;
         z_q     <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         cy_q    <= cy_d;
         z_q     <= z_d;
         done_q  <= done_d;
         err_q   <= err_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

   assign OUT_READY = (state_q == S_IDLE);
   assign OUT_DONE  = done_q;
   assign OUT_ERR   = err_q;
   assign OUT_A     = a_q;
   assign OUT_CY    = cy_q;
   assign OUT_Z     = z_q;

endmodule

// File: tb/tb_alu_acc.sv
module tb_alu_acc;

   logic       CLK = 1'b0;
   logic       RST;
   logic       IN_VALID;
   logic [3:0] IN_OP;
   logic [7:0] IN_R;
   logic       OUT_READY;
   logic       OUT_DONE;
   logic       OUT_ERR;
   logic [7:0] OUT_A;
   logic       OUT_CY;
   logic       OUT_Z;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_a;
   int m_cy;
   int m_err;

   typedef struct {
      int op;
      int r;
      int exp_a;
      int exp_cy;
      int exp_err;
   } vec_t;

   vec_t vq[$];

   alu_acc #(.WIDTH(8), .MUL_EN(1)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_OP     (IN_OP),
      .IN_R      (IN_R),
      .OUT_READY (OUT_READY),
      .OUT_DONE  (OUT_DONE),
      .OUT_ERR   (OUT_ERR),
      .OUT_A     (OUT_A),
      .OUT_CY    (OUT_CY),
      .OUT_Z     (OUT_Z)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input int op, input int r, input int a, input int cy, input int err);
      vec_t v;
      v.op = op; v.r = r; v.exp_a = a; v.exp_cy = cy; v.exp_err = err;
      vq.push_back(v);
   endtask

   // Architectural effect of one accepted op, from plain integer arithmetic.
   task automatic model_step(input int op, input int r);
      int s;
      m_err = 0;
      case (op)
         0:  begin s = m_a + r;        m_cy = (s > 255) ? 1 : 0; m_a = s % 256; end
         1:  begin m_cy = (r > m_a) ? 1 : 0; m_a = (m_a - r + 256) % 256; end
         2:  begin m_a = m_a | r; m_cy = 0; end
         3:  begin m_a = m_a & r; m_cy = 0; end
         4:  begin m_a = m_a ^ r; m_cy = 0; end
         5:  begin m_a = 255 - m_a; m_cy = 0; end
         6:  begin m_a = r; end
         7:  begin s = m_a + r + m_cy; m_cy = (s > 255) ? 1 : 0; m_a = s % 256; end
         8:  begin s = m_a - r - m_cy; m_cy = (s < 0) ? 1 : 0; m_a = (s + 512) % 256; end
         9:  begin m_cy = m_a / 128; m_a = (m_a * 2) % 256; end
         10: begin m_cy = m_a % 2; m_a = m_a / 2; end
         11: begin s = m_a * r; m_cy = (s > 255) ? 1 : 0; m_a = s % 256; end
         default: m_err = 1;
      endcase
   endtask

   // Called at a negedge; returns at the negedge where the result is visible.
   // While the block is busy, IN_VALID is held high with junk ops that must be ignored.
   task automatic run_op(input int op, input int r, input int old_a,
                         input int exp_a, input int exp_cy, input int exp_err);
      int busy;
      int opv;
      int rv;
      opv = op;
      rv  = r;
      IN_VALID = 1'b1;
      IN_OP    = opv[3:0];
      IN_R     = rv[7:0];
      @(negedge CLK);
      IN_VALID = 1'b0;
      busy = 0;
      while (!OUT_READY && busy < 20) begin
         chk("busy_done", int'(OUT_DONE), 0);
         chk("busy_hold_a", int'(OUT_A), old_a);
         IN_VALID = 1'b1;
         IN_OP    = 4'($urandom_range(0, 15));
         IN_R     = 8'($urandom);
         busy++;
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      if (op == 11) chk("mul_latency", busy, 8);
      else          chk("single_latency", busy, 0);
      chk("done", int'(OUT_DONE), 1);
      chk("err", int'(OUT_ERR), exp_err);
      chk("acc", int'(OUT_A), exp_a);
      chk("cy", int'(OUT_CY), exp_cy);
      chk("z", int'(OUT_Z), (exp_a == 0) ? 1 : 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a"}, int'(OUT_A), 0);
      chk({tag, "_cy"}, int'(OUT_CY), 0);
      chk({tag, "_z"}, int'(OUT_Z), 1);
      chk({tag, "_ready"}, int'(OUT_READY), 1);
      chk({tag, "_done"}, int'(OUT_DONE), 0);
      chk({tag, "_err"}, int'(OUT_ERR), 0);
   endtask

   initial begin
      int cur_a;
      int old_a;
      int op;
      int r;

      // directed vectors: op, R, expected A, CY, ERR
      add_vec(6,  'hFF, 'hFF, 0, 0);
      add_vec(0,  'h01, 'h00, 1, 0);
      add_vec(6,  'h00, 'h00, 1, 0);
      add_vec(1,  'h01, 'hFF, 1, 0);
      add_vec(8,  'h00, 'hFE, 0, 0);
      add_vec(6,  'hAA, 'hAA, 0, 0);
      add_vec(2,  'h55, 'hFF, 0, 0);
      add_vec(3,  'h0F, 'h0F, 0, 0);
      add_vec(4,  'hFF, 'hF0, 0, 0);
      add_vec(5,  'h00, 'h0F, 0, 0);
      add_vec(9,  'h00, 'h1E, 0, 0);
      add_vec(10, 'h00, 'h0F, 0, 0);
      add_vec(10, 'h00, 'h07, 1, 0);
      add_vec(6,  'h10, 'h10, 1, 0);
      add_vec(0,  'hF0, 'h00, 1, 0);
      add_vec(7,  'h05, 'h06, 0, 0);
      add_vec(6,  'h0C, 'h0C, 0, 0);
      add_vec(11, 'h0B, 'h84, 0, 0);
      add_vec(6,  'h20, 'h20, 0, 0);
      add_vec(11, 'h10, 'h00, 1, 0);
      add_vec(13, 'h00, 'h00, 1, 1);
      add_vec(6,  'hFF, 'hFF, 1, 0);
      add_vec(7,  'h00, 'h00, 1, 0);
      add_vec(8,  'hFF, 'h00, 1, 0);
      add_vec(6,  'h05, 'h05, 1, 0);
      add_vec(11, 'h00, 'h00, 0, 0);
      add_vec(15, 'h33, 'h00, 0, 1);

      RST = 1'b1; IN_VALID = 1'b0; IN_OP = 4'd0; IN_R = 8'd0;
      #1;
      chk_reset_vals("reset");
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk_reset_vals("post_reset");

      // directed table, back-to-back with IN_VALID held high
      cur_a = 0;
      foreach (vq[i]) begin
         run_op(vq[i].op, vq[i].r, cur_a, vq[i].exp_a, vq[i].exp_cy, vq[i].exp_err);
         cur_a = vq[i].exp_a;
      end
      @(negedge CLK);
      chk("done_drop", int'(OUT_DONE), 0);
      chk("err_drop", int'(OUT_ERR), 0);
      m_a  = cur_a;
      m_cy = vq[vq.size()-1].exp_cy;

      // randomized ops against the model
      for (int k = 0; k < 250; k++) begin
         op = $urandom_range(0, 15);
         r  = $urandom_range(0, 255);
         if ($urandom_range(0, 9) == 0) r = 0;
         if ($urandom_range(0, 9) == 0) r = 255;
         old_a = m_a;
         model_step(op, r);
         run_op(op, r, old_a, m_a, m_cy, m_err);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge CLK);
            chk("gap_done", int'(OUT_DONE), 0);
            chk("gap_err", int'(OUT_ERR), 0);
            chk("gap_a", int'(OUT_A), m_a);
         end
      end

      // reset during a multiply: no result, no done pulse
      run_op(6, 'h0C, m_a, 'h0C, m_cy, 0);
      IN_VALID = 1'b1; IN_OP = 4'd11; IN_R = 8'h0B;
      @(negedge CLK);
      IN_VALID = 1'b0;
      chk("mul_busy", int'(OUT_READY), 0);
      @(negedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      chk_reset_vals("mid_mul_reset");
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         chk("after_reset_done", int'(OUT_DONE), 0);
         chk("after_reset_a", int'(OUT_A), 0);
         chk("after_reset_ready", int'(OUT_READY), 1);
      end
      run_op(0, 'h03, 0, 'h03, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
